palette_lookup_arbiter: RTL and testbench

//  Shares one sprite palette lookup (4-bit index -> 4-bit R/G/B, combinational) among
//  NUM_REQ sprite renderers (tank, bullets, explosion). Round-robin with bounded bursts.

---
 rtl/palette_lookup_arbiter.sv | 161 ++++++++++++++++
 tb/tb_palette_lookup_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/palette_lookup_arbiter.sv
// palette_lookup_arbiter
//   Shares one combinational sprite palette lookup among NUM_REQ sprite renderers.
//   Round-robin arbitration with bursts of at most MAX_BURST lookups per owner.
//   The winning requester's index is driven to the palette; the returned RGB is
//   registered and handed back one cycle later, tagged with the requester ID.
//
// Ports
//   Clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   frame_start  1-cycle pulse, forces the arbiter back to idle with pointer 0
//   req          per-requester lookup request, held until served
//   idx          per-requester palette index, slice i belongs to requester i
//   gnt          registered one-hot grant, zero when idle
//   pal_index    index to the palette (idx of owner while owning, else 0)
//   pal_red/green/blue  palette output for pal_index, same cycle
//   rsp_valid    result valid, one cycle after a lookup
//   rsp_id       requester that issued the lookup
//   rsp_red/green/blue  captured palette colour
module palette_lookup_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned IDX_W     = 4,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                       Clk,
    input  logic                       reset_n,
    input  logic                       frame_start,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*IDX_W-1:0]   idx,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [IDX_W-1:0]           pal_index,
    input  logic [3:0]                 pal_red,
    input  logic [3:0]                 pal_green,
    input  logic [3:0]                 pal_blue,
    output logic                       rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic [3:0]                 rsp_red,
    output logic [3:0]                 rsp_green,
    output logic [3:0]                 rsp_blue
);

    localparam int unsigned ID_W  = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_OWN  = 1'b1;

    logic [0:0]       state, state_d;
    logic [ID_W-1:0]  owner, owner_d;
    logic [ID_W-1:0]  ptr, ptr_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [NUM_REQ-1:0] gnt_d;
    logic [ID_W-1:0]  owner_inc;
    logic             fire;

    // First requester at or after 'start', wrapping modulo NUM_REQ.
    function automatic logic [ID_W-1:0] pick(input logic [NUM_REQ-1:0] r,
                                             input logic [ID_W-1:0]    start);
        logic [ID_W-1:0] res;
        logic            found;
        int unsigned     j;
        res   = start;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            j = (32'(start) + i) % NUM_REQ;
            if (!found && r[j]) begin
                res   = ID_W'(j);
                found = 1'b1;
            end
        end
        return res;
    endfunction

    assign owner_inc = ID_W'((32'(owner) + 32'd1) % NUM_REQ);
    assign fire      = (state == ST_OWN) && req[owner];

    always_comb begin
        state_d = state;
        owner_d = owner;
        cnt_d   = cnt;
        ptr_d   = ptr;
        if (frame_start) begin
            state_d = ST_IDLE;
            ptr_d   = '0;
            cnt_d   = '0;
        end else if (state == ST_IDLE) begin
            if (|req) begin
                state_d = ST_OWN;
                owner_d = pick(req, ptr);
                cnt_d   = '0;
            end
        end else if (!req[owner]) begin
            // Owner withdrew without a lookup: hand over or go idle.
            ptr_d = owner_inc;
            cnt_d = '0;
            if (|req) begin
                owner_d = pick(req, owner_inc);
            end else begin
                state_d = ST_IDLE;
            end
        end else if (cnt != CNT_W'(MAX_BURST - 1)) begin
            cnt_d = cnt + 1'b1;
        end else begin
            // Burst exhausted; a lone requester simply wins again with no bubble.
            ptr_d   = owner_inc;
            owner_d = pick(req, owner_inc);
            cnt_d   = '0;
        end

        gnt_d = '0;
        if (state_d == ST_OWN) begin
            gnt_d = NUM_REQ'(1) << owner_d;
        end
    end

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            owner <= '0;
            ptr   <= '0;
            cnt   <= '0;
            gnt   <= '0;
        end else begin
            state <= state_d;
            owner <= owner_d;
            ptr   <= ptr_d;
            cnt   <= cnt_d;
            gnt   <= gnt_d;
        end
    end

    // Response path is independent of frame_start so an in-flight lookup completes.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_red   <= '0;
            rsp_green <= '0;
            rsp_blue  <= '0;
        end else begin
            rsp_valid <= fire;
            if (fire) begin
                rsp_id    <= owner;
                rsp_red   <= pal_red;
                rsp_green <= pal_green;
                rsp_blue  <= pal_blue;
            end
        end
    end

    always_comb begin
        pal_index = '0;
        if (state == ST_OWN) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (owner == ID_W'(i)) begin
                    pal_index = idx[i*IDX_W +: IDX_W];
                end
            end
        end
    end

endmodule

// File: tb/tb_palette_lookup_arbiter.sv
// Testbench for palette_lookup_arbiter: directed vector tables, hand-written
// corner sequences, and randomized traffic checked against a behavioural model.
module tb_palette_lookup_arbiter;

    localparam int N  = 4;
    localparam int W  = 4;
    localparam int MB = 4;

    logic        Clk = 1'b0;
    logic        reset_n;
    logic        frame_start;
    logic [3:0]  req;
    logic [15:0] idx;
    logic [3:0]  gnt;
    logic [3:0]  pal_index;
    logic [3:0]  pal_red, pal_green, pal_blue;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [3:0]  rsp_red, rsp_green, rsp_blue;

    int checks = 0;
    int passed = 0;

    palette_lookup_arbiter #(.NUM_REQ(N), .IDX_W(W), .MAX_BURST(MB)) dut (
        .Clk(Clk), .reset_n(reset_n), .frame_start(frame_start),
        .req(req), .idx(idx), .gnt(gnt), .pal_index(pal_index),
        .pal_red(pal_red), .pal_green(pal_green), .pal_blue(pal_blue),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_red(rsp_red), .rsp_green(rsp_green), .rsp_blue(rsp_blue)
    );

    always #5 Clk = ~Clk;

    // Palette contents as {R,G,B}.
    function automatic logic [11:0] pal(input logic [3:0] i);
        case (i)
            4'h0:    return 12'hFFF;
            4'h3:    return 12'hD53;
            4'h9:    return 12'hFE4;
            4'hF:    return 12'hEA4;
            default: return {i, ~i, i ^ 4'h5};
        endcase
    endfunction

    assign {pal_red, pal_green, pal_blue} = pal(pal_index);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    bit          m_own;
    int          m_owner, m_cnt, m_ptr;
    bit          m_rv;
    int          m_rid;
    logic [11:0] m_rgb;

    function automatic int mpick(input logic [3:0] r, input int s);
        for (int k = 0; k < N; k++)
            if (r[(s + k) % N]) return (s + k) % N;
        return s;
    endfunction

    task automatic model_reset();
        m_own = 0; m_owner = 0; m_cnt = 0; m_ptr = 0;
        m_rv = 0; m_rid = 0; m_rgb = '0;
    endtask

    task automatic model_step();
        bit fire;
        fire = m_own && req[m_owner];
        m_rv = fire;
        if (fire) begin
            m_rid = m_owner;
            m_rgb = pal(idx[m_owner*W +: W]);
        end
        if (frame_start) begin
            m_own = 0; m_ptr = 0; m_cnt = 0;
        end else if (!m_own) begin
            if (req != 0) begin m_own = 1; m_owner = mpick(req, m_ptr); m_cnt = 0; end
        end else if (!req[m_owner]) begin
            m_ptr = (m_owner + 1) % N;
            m_cnt = 0;
            if (req != 0) m_owner = mpick(req, m_ptr);
            else m_own = 0;
        end else if (m_cnt < MB - 1) begin
            m_cnt++;
        end else begin
            m_ptr = (m_owner + 1) % N;
            m_owner = mpick(req, m_ptr);
            m_cnt = 0;
        end
    endtask

    task automatic model_check();
        chk("rnd_gnt", 32'(gnt), m_own ? (32'd1 << m_owner) : 32'd0);
        chk("rnd_pal_index", 32'(pal_index), m_own ? 32'(idx[m_owner*W +: W]) : 32'd0);
        chk("rnd_rsp_valid", 32'(rsp_valid), 32'(m_rv));
        if (m_rv) begin
            chk("rnd_rsp_id", 32'(rsp_id), 32'(m_rid));
            chk("rnd_rsp_rgb", 32'({rsp_red, rsp_green, rsp_blue}), 32'(m_rgb));
        end
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        bit         rst;
        logic [3:0] req;
        logic       fs;
        logic [3:0] gnt;
        logic       rv;
        logic [1:0] rid;
    } vec_t;

    vec_t tbl[$];
    logic [11:0] id_rgb [4];

    function automatic vec_t mk(input bit rst, input logic [3:0] r, input logic [3:0] g,
                                input logic rv, input logic [1:0] rid);
        vec_t v;
        v.rst = rst; v.req = r; v.fs = 1'b0; v.gnt = g; v.rv = rv; v.rid = rid;
        return v;
    endfunction

    task automatic do_reset();
        @(negedge Clk);
        reset_n = 1'b0; req = '0; frame_start = 1'b0;
        #1;
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_rgb", 32'({rsp_red, rsp_green, rsp_blue}), 0);
        chk("rst_pal_index", 32'(pal_index), 0);
        @(negedge Clk);
        reset_n = 1'b1;
        model_reset();
        #1;
        chk("rst_hold_gnt", 32'(gnt), 0);
        chk("rst_hold_rsp_valid", 32'(rsp_valid), 0);
    endtask

    task automatic step(input logic [3:0] r, input logic fs);
        @(negedge Clk);
        req = r; frame_start = fs;
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int id2_rsp;
        reset_n = 1'b0; req = '0; frame_start = 1'b0; idx = 16'hF930;
        id_rgb[0] = 12'hFFF; id_rgb[1] = 12'hD53; id_rgb[2] = 12'hFE4; id_rgb[3] = 12'hEA4;

        // Single requester 1: contiguous grants across burst boundaries.
        tbl.push_back(mk(1, 4'b0010, 4'b0000, 0, 0));
        tbl.push_back(mk(0, 4'b0010, 4'b0010, 0, 0));
        for (int i = 0; i < 5; i++) tbl.push_back(mk(0, 4'b0010, 4'b0010, 1, 1));
        tbl.push_back(mk(0, 4'b0000, 4'b0010, 1, 1));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 0));
        // All four requesting: bursts of 4 in order 0,1,2,3,0.
        tbl.push_back(mk(1, 4'b1111, 4'b0000, 0, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b0001, 0, 0));
        for (int o = 0; o < 4; o++) begin
            tbl.push_back(mk(0, 4'b1111, 4'b0001 << o, 1, 2'(o == 0 ? 0 : o - 1)));
            if (o == 0) tbl.pop_back();
            if (o == 0) begin
                for (int k = 0; k < 3; k++) tbl.push_back(mk(0, 4'b1111, 4'b0001, 1, 0));
            end else begin
                for (int k = 0; k < 3; k++) tbl.push_back(mk(0, 4'b1111, 4'b0001 << o, 1, 2'(o)));
            end
        end
        tbl.push_back(mk(0, 4'b1111, 4'b0001, 1, 3));
        tbl.push_back(mk(0, 4'b1111, 4'b0001, 1, 0));
        tbl.push_back(mk(0, 4'b0000, 4'b0001, 1, 0));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 0));

        foreach (tbl[n]) begin
            if (tbl[n].rst) do_reset();
            step(tbl[n].req, tbl[n].fs);
            chk($sformatf("vec%0d_gnt", n), 32'(gnt), 32'(tbl[n].gnt));
            chk($sformatf("vec%0d_rsp_valid", n), 32'(rsp_valid), 32'(tbl[n].rv));
            if (tbl[n].rv) begin
                chk($sformatf("vec%0d_rsp_id", n), 32'(rsp_id), 32'(tbl[n].rid));
                chk($sformatf("vec%0d_rsp_rgb", n), 32'({rsp_red, rsp_green, rsp_blue}),
                    32'(id_rgb[tbl[n].rid]));
            end
        end

        // Owner 2 withdraws after two lookups while requester 0 waits.
        do_reset();
        id2_rsp = 0;
        step(4'b0100, 0); chk("drop_gnt0", 32'(gnt), 32'b0000);
        step(4'b0101, 0); chk("drop_gnt1", 32'(gnt), 32'b0100);
        if (rsp_valid && rsp_id == 2) id2_rsp++;
        step(4'b0101, 0); chk("drop_gnt2", 32'(gnt), 32'b0100);
        if (rsp_valid && rsp_id == 2) id2_rsp++;
        step(4'b0001, 0); chk("drop_gnt3", 32'(gnt), 32'b0100);
        if (rsp_valid && rsp_id == 2) id2_rsp++;
        step(4'b0001, 0); chk("drop_gnt4", 32'(gnt), 32'b0001);
        chk("drop_no_rsp", 32'(rsp_valid), 0);
        if (rsp_valid && rsp_id == 2) id2_rsp++;
        step(4'b0000, 0);
        if (rsp_valid && rsp_id == 2) id2_rsp++;
        chk("drop_rsp_id0", 32'(rsp_id), 0);
        chk("drop_id2_rsp_count", 32'(id2_rsp), 2);

        // frame_start in the middle of owner 3's burst.
        do_reset();
        step(4'b1000, 0); chk("fs_gnt0", 32'(gnt), 32'b0000);
        step(4'b1000, 0); chk("fs_gnt1", 32'(gnt), 32'b1000);
        step(4'b1010, 1); chk("fs_gnt2", 32'(gnt), 32'b1000);
        step(4'b1010, 0); chk("fs_gnt_idle", 32'(gnt), 32'b0000);
        chk("fs_inflight_valid", 32'(rsp_valid), 1);
        chk("fs_inflight_id", 32'(rsp_id), 3);
        step(4'b1010, 0); chk("fs_gnt_ptr0", 32'(gnt), 32'b0010);
        chk("fs_no_rsp", 32'(rsp_valid), 0);
        step(4'b1010, 0); chk("fs_rsp_id", 32'(rsp_id), 1);
        chk("fs_rsp_rgb", 32'({rsp_red, rsp_green, rsp_blue}), 32'h0D53);

        // Asynchronous reset in the middle of a burst.
        do_reset();
        step(4'b1111, 0);
        step(4'b1111, 0); chk("ar_gnt", 32'(gnt), 32'b0001);
        step(4'b1111, 0); chk("ar_rsp_before", 32'(rsp_valid), 1);
        #2;
        reset_n = 1'b0;
        req = 4'b0110;
        #1;
        chk("ar_rsp_drop", 32'(rsp_valid), 0);
        chk("ar_gnt_drop", 32'(gnt), 0);
        chk("ar_rgb_clear", 32'({rsp_red, rsp_green, rsp_blue}), 0);
        @(negedge Clk);
        reset_n = 1'b1;
        @(negedge Clk);
        #1;
        chk("ar_first_gnt", 32'(gnt), 32'b0010);

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            logic [3:0] r;
            @(negedge Clk);
            r = req;
            for (int i = 0; i < N; i++) begin
                if (r[i]) begin
                    if ($urandom_range(5) == 0) r[i] = 1'b0;
                end else if ($urandom_range(3) == 0) begin
                    r[i] = 1'b1;
                end
            end
            req = r;
            frame_start = ($urandom_range(39) == 0);
            idx = 16'($urandom);
            #1;
            model_check();
            model_step();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
